seg_display_ctrl: RTL and testbench

Display controller for the 4-digit common-anode 7-segment board display. It captures an 8-bit binary value from the processor and converts it to BCD sequentially using double-dabble, one shift per clock. It then time-multiplexes the digits, feeding each nibble through one decoder_7_seg instance and driving the active-low anodes. It sits between the processor output register and the board pins.

---
 rtl/seg_display_ctrl_pkg.sv | 11 +
 rtl/seg_display_ctrl_if.sv | 14 +
 rtl/seg_display_ctrl_decoder_7_seg.sv | 22 ++
 rtl/seg_display_ctrl.sv | 68 ++++++
 tb/tb_seg_display_ctrl.sv | 132 +++++++++++++
 5 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// seg_display_ctrl_pkg: shared display constants, conversion states and the double-dabble nibble correction
package seg_display_ctrl_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'b1111;
  localparam logic [3:0] NIB_BLANK = 4'hF;
  localparam int BCD_ITER = 8;
  typedef enum logic {IDLE, CONV} state_t;
  function automatic logic [3:0] dd_fix(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: processor-side value/strobe/options and board-side anode/cathode pins
// value/load/blank_lz/dp_en: driven by the processor (master)
// busy/an/seg: driven by the controller (slave)
interface seg_display_ctrl_if;
  logic [7:0] value;
  logic load;
  logic blank_lz;
  logic [3:0] dp_en;
  logic busy;
  logic [3:0] an;
  logic [7:0] seg;
  modport master (output value, load, blank_lz, dp_en, input busy, an, seg);
  modport slave (input value, load, blank_lz, dp_en, output busy, an, seg);
endinterface

// File: rtl/seg_display_ctrl_decoder_7_seg.sv
// decoder_7_seg: active-low 7-segment font for decimal digits, all segments off otherwise
// nib: digit to show; seg[6:0]: cathodes g..a, active-low
module decoder_7_seg (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'h7F;
    endcase
  end
endmodule

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: 8-bit binary to BCD (double-dabble) with multiplexed 4-digit common-anode drive
// clk/rst: system clock, asynchronous active-high reset
// bus.value/load: value captured on load while idle; bus.busy high during the 8 conversion cycles
// bus.blank_lz/dp_en: leading-zero blanking and per-digit decimal points, sampled at each slot edge
// bus.an/seg: registered active-low anodes and cathodes (seg[7]=dp)
module seg_display_ctrl
  import seg_display_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input logic clk,
  input logic rst,
  seg_display_ctrl_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(BCD_ITER);
  state_t state, state_nxt;
  logic [19:0] sr, sr_nxt;
  logic [IW-1:0] it;
  logic [3:0] hun, ten, one, nib;
  logic [PW-1:0] pre;
  logic [1:0] idx, idx_nxt;
  logic [6:0] dec;
  logic slot, done;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    sr_nxt = {dd_fix(sr[19:16]), dd_fix(sr[15:12]), dd_fix(sr[11:8]), sr[7:0]} << 1;
    done = state == CONV && it == IW'(BCD_ITER - 1);
    state_nxt = state == IDLE ? (bus.load ? CONV : IDLE) : (done ? IDLE : CONV);
    slot = pre == PW'(REFRESH_DIV - 1);
    idx_nxt = idx + 2'd1;
    nib = idx_nxt == 2'd0 ? one :
          idx_nxt == 2'd1 ? (bus.blank_lz && hun == 4'd0 && ten == 4'd0 ? NIB_BLANK : ten) :
          idx_nxt == 2'd2 ? (bus.blank_lz && hun == 4'd0 ? NIB_BLANK : hun) : NIB_BLANK;
  end
  assign bus.busy = state == CONV;
  // digits change only on the final shift, so the scan never sees a partial result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      it <= '0;
      {hun, ten, one} <= '0;
    end else if (state == IDLE && bus.load) begin
      sr <= {12'b0, bus.value};
      it <= '0;
    end else if (state == CONV) begin
      sr <= sr_nxt;
      it <= it + 1'b1;
      if (done) {hun, ten, one} <= sr_nxt[19:8];
    end
  decoder_7_seg u_dec (.nib(nib), .seg(dec));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pre <= '0;
      idx <= 2'd3;
      bus.an <= AN_OFF;
      bus.seg <= SEG_BLANK;
    end else begin
      pre <= slot ? '0 : pre + 1'b1;
      if (slot) begin
        idx <= idx_nxt;
        bus.an <= ~(4'b0001 << idx_nxt);
        bus.seg <= {~bus.dp_en[idx_nxt], dec};
      end
    end
endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed and random stimulus checked against a decimal-arithmetic display model
module tb_seg_display_ctrl;
  localparam int DIV = 4;
  logic clk = 0, rst = 1;
  int n_chk = 0, n_err = 0;
  seg_display_ctrl_if bus();
  seg_display_ctrl #(.REFRESH_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] font [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int edge_cnt, busy_left, pend_val, disp_val, m_idx;
  logic [3:0] m_an;
  logic [7:0] m_seg;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    edge_cnt = 0; busy_left = 0; pend_val = 0; disp_val = 0; m_idx = 3;
    m_an = 4'hF; m_seg = 8'hFF;
  endtask
  task automatic model_edge();
    int h, t, o, d;
    logic bl;
    edge_cnt++;
    if (edge_cnt % DIV == 0) begin
      m_idx = (m_idx + 1) % 4;
      h = disp_val / 100; t = (disp_val / 10) % 10; o = disp_val % 10;
      case (m_idx)
        0: begin d = o; bl = 0; end
        1: begin d = t; bl = bus.blank_lz && h == 0 && t == 0; end
        2: begin d = h; bl = bus.blank_lz && h == 0; end
        default: begin d = 0; bl = 1; end
      endcase
      m_an = ~(4'(1) << m_idx);
      m_seg = {~bus.dp_en[m_idx], bl ? 7'h7F : font[d]};
    end
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) disp_val = pend_val;
    end else if (bus.load) begin
      pend_val = int'(bus.value);
      busy_left = 8;
    end
  endtask
  task automatic check_all();
    chk("busy", 32'(bus.busy), 32'(busy_left > 0));
    chk("an", 32'(bus.an), 32'(m_an));
    chk("seg", 32'(bus.seg), 32'(m_seg));
  endtask
  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      check_all();
    end
  endtask
  task automatic do_reset(int n);
    rst = 1;
    model_reset();
    #1;
    check_all();
    repeat (n) @(posedge clk);
    #1;
    check_all();
    rst = 0;
  endtask
  task automatic do_load(logic [7:0] v);
    bus.value = v;
    bus.load = 1;
    step();
    bus.load = 0;
  endtask
  initial begin
    int bc;
    bus.value = 0; bus.load = 0; bus.blank_lz = 0; bus.dp_en = 0;
    model_reset();
    @(negedge clk);
    do_reset(3);
    step(6);
    step(5);
    do_reset(3);
    step(12);
    bc = 0;
    do_load(8'd255);
    bc = int'(bus.busy);
    for (int i = 0; i < 20 && bus.busy; i++) begin
      step();
      if (bus.busy) bc++;
    end
    chk("busy_len", 32'(bc), 32'd8);
    step(20);
    bus.blank_lz = 1;
    do_load(8'd7);
    step(24);
    bus.blank_lz = 0;
    step(20);
    do_load(8'd105);
    step(2);
    do_load(8'd42);
    step(24);
    bus.blank_lz = 1;
    step(20);
    bus.blank_lz = 0;
    bus.dp_en = 4'b0010;
    do_load(8'd12);
    step(24);
    bus.dp_en = 0;
    do_load(8'd200);
    step(3);
    do_reset(1);
    step(20);
    do_load(8'd200);
    step(24);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        bus.value = 8'($urandom);
        bus.load = 1;
      end
      if ($urandom_range(0, 30) == 0) bus.blank_lz = 1'($urandom);
      if ($urandom_range(0, 30) == 0) bus.dp_en = 4'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      step();
      bus.load = 0;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
